ipe_op_sequencer: RTL

//  Upstream driver for the image processing core. Buffers host commands (4-bit op

---
 rtl/ipe_op_sequencer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/ipe_op_sequencer.sv
// rtl/ipe_op_sequencer.sv - host-side command/frame sequencer feeding the image processing core
//
// ipe_cmd_fifo ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_push, i_data[3:0]    push request and op mode (ignored while full)
//   i_pop                  pop request (caller only pops when not empty)
//   o_data[3:0]            head entry
//   o_full, o_empty        occupancy flags
//
// ipe_op_sequencer ports:
//   i_clk, i_rst                           clock, synchronous active-high reset
//   i_cmd_valid, i_cmd_mode, o_cmd_ready   host command push
//   i_pix_valid, i_pix_data, o_pix_ready   host frame write, raster order
//   o_op_valid, o_op_mode, i_op_ready      op handshake to the core
//   o_in_valid, o_in_data, i_in_ready      frame stream to the core
//   i_out_valid                            core result strobe, counted into o_res_cnt
//   o_busy, o_err, o_res_cnt               status

module ipe_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [3:0] i_data,
  input  logic       i_pop,
  output logic [3:0] o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [3:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_data  = mem_q[rd_ptr_q];
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end
endmodule

module ipe_op_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int FRAME_PIX = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  input  logic [3:0]  i_cmd_mode,
  output logic        o_cmd_ready,
  input  logic        i_pix_valid,
  input  logic [7:0]  i_pix_data,
  output logic        o_pix_ready,
  output logic        o_op_valid,
  output logic [3:0]  o_op_mode,
  input  logic        i_op_ready,
  output logic        o_in_valid,
  output logic [7:0]  o_in_data,
  input  logic        i_in_ready,
  input  logic        i_out_valid,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_res_cnt
);
  localparam int PW = $clog2(FRAME_PIX);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] K_LAST   = PW'(FRAME_PIX - 1);
  localparam logic [CW-1:0] PIX_FULL = CW'(FRAME_PIX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_WAIT_LO,
    S_WAIT_HI
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    mode_q, mode_d;
  logic          op_valid_q, op_valid_d;
  logic          in_valid_q, in_valid_d;
  logic [7:0]    in_data_q, in_data_d;
  logic          err_q, err_d;
  logic          sync_lost_q, sync_lost_d;
  logic [PW-1:0] k_q, k_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]   res_cnt_q, res_cnt_d;

  logic [7:0]    frame_q [FRAME_PIX];

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [3:0]    head;
  logic          pix_full, pix_wr;

  ipe_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_cmd_valid),
    .i_data  (i_cmd_mode),
    .i_pop   (fifo_pop),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign pix_full    = (pix_cnt_q == PIX_FULL);
  assign o_pix_ready = !pix_full && (state_q != S_STREAM);
  assign pix_wr      = i_pix_valid && o_pix_ready;
  assign o_cmd_ready = !fifo_full;
  assign o_busy      = (state_q != S_IDLE) || !fifo_empty;
  assign o_op_valid  = op_valid_q;
  assign o_op_mode   = mode_q;
  assign o_in_valid  = in_valid_q;
  assign o_in_data   = in_data_q;
  assign o_err       = err_q;
  assign o_res_cnt   = res_cnt_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    op_valid_d  = 1'b0;
    in_valid_d  = 1'b0;
    in_data_d   = 8'd0;
    err_d       = 1'b0;
    sync_lost_d = sync_lost_q;
    k_d         = k_q;
    pix_cnt_d   = pix_cnt_q + CW'(pix_wr);
    res_cnt_d   = res_cnt_q + 16'(i_out_valid);
    fifo_pop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (head >= 4'd11) begin
            // Illegal modes are dropped so they cannot wedge the queue.
            fifo_pop = 1'b1;
            err_d    = 1'b1;
          end else if (i_op_ready && (head != 4'd0 || pix_full)) begin
            fifo_pop   = 1'b1;
            op_valid_d = 1'b1;
            mode_d     = head;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (mode_q == 4'd0) begin
          // Preload pixel 0 so the stream starts the cycle after the op pulse.
          state_d     = S_STREAM;
          in_valid_d  = 1'b1;
          in_data_d   = frame_q[0];
          k_d         = '0;
          sync_lost_d = 1'b0;
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_STREAM: begin
        // The core only raises in_ready from the second beat on.
        if (k_q != '0 && !i_in_ready && !sync_lost_q) begin
          err_d       = 1'b1;
          sync_lost_d = 1'b1;
        end
        if (k_q == K_LAST) begin
          state_d   = S_WAIT_LO;
          pix_cnt_d = '0;
        end else begin
          k_d        = k_q + PW'(1);
          in_valid_d = 1'b1;
          in_data_d  = frame_q[k_q + PW'(1)];
        end
      end
      S_WAIT_LO: begin
        if (!i_op_ready) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (i_op_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 4'd0;
      op_valid_q  <= 1'b0;
      in_valid_q  <= 1'b0;
      in_data_q   <= 8'd0;
      err_q       <= 1'b0;
      sync_lost_q <= 1'b0;
      k_q         <= '0;
      pix_cnt_q   <= '0;
      res_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      op_valid_q  <= op_valid_d;
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      err_q       <= err_d;
      sync_lost_q <= sync_lost_d;
      k_q         <= k_d;
      pix_cnt_q   <= pix_cnt_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (pix_wr) frame_q[pix_cnt_q[PW-1:0]] <= i_pix_data;
  end
endmodule
